// File: rtl/td4_ctrl_seq.sv
// td4_ctrl_seq -- registered control sequencer for the TD4 datapath.
//
// Takes one instruction word per CMD_VALID/CMD_READY handshake. It decodes the
// word into a one-cycle register-load strobe, an ALU source select and an
// immediate. It owns the carry flag used by JNC, traps undefined opcodes, and
// counts retired legal instructions.
//
// Ports:
//   CLK, RST_N      clock (rising edge), asynchronous active-low reset
//   CMD_VALID/READY instruction handshake from fetch
//   COMMAND         {opcode[3:0], imm[IMM_W-1:0]}
//   ALU_CARRY       adder carry-out, sampled when a legal instruction retires
//   IM, SEL, LOAD   registered immediate, ALU source (00 A/01 B/10 IN/11 zero),
//                   one-hot load strobe (bit0 A, bit1 B, bit2 OUT, bit3 PC)
//   CFLAG           registered carry flag
//   ILLEGAL         sticky flag: an undefined opcode was accepted
//   HALTED          sequencer is halted (only reset leaves this state)
//   RETIRED         retired legal-instruction count, wraps modulo 2^CNT_W
module td4_ctrl_seq #(
  parameter int unsigned IMM_W           = 4,
  parameter int unsigned CNT_W           = 16,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               CMD_VALID,
  output logic               CMD_READY,
  input  logic [IMM_W+3:0]   COMMAND,
  input  logic               ALU_CARRY,
  output logic [IMM_W-1:0]   IM,
  output logic [1:0]         SEL,
  output logic [3:0]         LOAD,
  output logic               CFLAG,
  output logic               ILLEGAL,
  output logic               HALTED,
  output logic [CNT_W-1:0]   RETIRED
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IMM_W-1:0] im_q, im_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       load_q, load_d;
  logic             legal_q, legal_d;
  logic             cflag_q, cflag_d;
  logic             ill_q, ill_d;
  logic [CNT_W-1:0] ret_q, ret_d;

  logic [3:0]       opcode;
  logic [1:0]       dec_sel;
  logic [3:0]       dec_load;
  logic             dec_legal;

  assign opcode = COMMAND[IMM_W+3:IMM_W];

  always_comb begin
    dec_sel   = 2'b11;
    dec_load  = '0;
    dec_legal = 1'b1;
    unique case (opcode)
      4'b0000: begin dec_sel = 2'b00; dec_load = 4'b0001; end
      4'b0101: begin dec_sel = 2'b01; dec_load = 4'b0010; end
      4'b0011: begin dec_sel = 2'b11; dec_load = 4'b0001; end
      4'b0111: begin dec_sel = 2'b11; dec_load = 4'b0010; end
      4'b0001: begin dec_sel = 2'b01; dec_load = 4'b0001; end
      4'b0100: begin dec_sel = 2'b00; dec_load = 4'b0010; end
      4'b0010: begin dec_sel = 2'b10; dec_load = 4'b0001; end
      4'b0110: begin dec_sel = 2'b10; dec_load = 4'b0010; end
      4'b1011: begin dec_sel = 2'b11; dec_load = 4'b0100; end
      4'b1001: begin dec_sel = 2'b01; dec_load = 4'b0100; end
      4'b1111: begin dec_sel = 2'b11; dec_load = 4'b1000; end
      // JNC uses the flag as registered at the accept edge, i.e. the carry
      // of the previously retired instruction.
      4'b1110: begin dec_sel = 2'b11; dec_load = cflag_q ? 4'b0000 : 4'b1000; end
      default: begin dec_sel = 2'b11; dec_load = 4'b0000; dec_legal = 1'b0; end
    endcase
  end

  always_comb begin
    state_d = state_q;
    im_d    = im_q;
    sel_d   = sel_q;
    load_d  = '0;
    legal_d = legal_q;
    cflag_d = cflag_q;
    ill_d   = ill_q;
    ret_d   = ret_q;
    unique case (state_q)
      ST_IDLE: begin
        if (CMD_VALID) begin
          state_d = ST_EXEC;
          im_d    = COMMAND[IMM_W-1:0];
          sel_d   = dec_sel;
          load_d  = dec_load;
          legal_d = dec_legal;
          if (!dec_legal) ill_d = 1'b1;
        end
      end
      ST_EXEC: begin
        if (legal_q) begin
          cflag_d = ALU_CARRY;
          ret_d   = ret_q + 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = HALT_ON_ILLEGAL ? ST_HALT : ST_IDLE;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      im_q    <= '0;
      sel_q   <= '1;
      load_q  <= '0;
      legal_q <= 1'b0;
      cflag_q <= 1'b0;
      ill_q   <= 1'b0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      im_q    <= im_d;
      sel_q   <= sel_d;
      load_q  <= load_d;
      legal_q <= legal_d;
      cflag_q <= cflag_d;
      ill_q   <= ill_d;
      ret_q   <= ret_d;
    end
  end

  // load_q is only non-zero during EXEC, and it is cleared by the asynchronous
  // reset, so the strobe drops the moment RST_N falls.
  assign CMD_READY = (state_q == ST_IDLE);
  assign HALTED    = (state_q == ST_HALT);
  assign IM        = im_q;
  assign SEL       = sel_q;
  assign LOAD      = load_q;
  assign CFLAG     = cflag_q;
  assign ILLEGAL   = ill_q;
  assign RETIRED   = ret_q;

endmodule

// File: tb/tb_td4_ctrl_seq.sv
// Bench for td4_ctrl_seq. It drives two instances from shared stimulus:
// dut0 uses the default parameters (halt on illegal, 16-bit count), and dut1
// runs illegal opcodes as NOP with a 2-bit count. A behavioural model of the
// instruction-level rules supplies the expected value of every output on
// every cycle. Directed sequences add hand-computed literal checks.
module tb_td4_ctrl_seq;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       CMD_VALID = 1'b0;
  logic       ALU_CARRY = 1'b0;
  logic [7:0] COMMAND = '0;

  logic       ready_o [2];
  logic [3:0] im_o    [2];
  logic [1:0] sel_o   [2];
  logic [3:0] load_o  [2];
  logic       cf_o    [2];
  logic       ill_o   [2];
  logic       halt_o  [2];
  logic [15:0] ret0;
  logic [1:0]  ret1;

  always #5 CLK = ~CLK;

  td4_ctrl_seq #(.IMM_W(4), .CNT_W(16), .HALT_ON_ILLEGAL(1'b1)) dut0 (
    .CLK(CLK), .RST_N(RST_N), .CMD_VALID(CMD_VALID), .CMD_READY(ready_o[0]),
    .COMMAND(COMMAND), .ALU_CARRY(ALU_CARRY), .IM(im_o[0]), .SEL(sel_o[0]),
    .LOAD(load_o[0]), .CFLAG(cf_o[0]), .ILLEGAL(ill_o[0]), .HALTED(halt_o[0]),
    .RETIRED(ret0));

  td4_ctrl_seq #(.IMM_W(4), .CNT_W(2), .HALT_ON_ILLEGAL(1'b0)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .CMD_VALID(CMD_VALID), .CMD_READY(ready_o[1]),
    .COMMAND(COMMAND), .ALU_CARRY(ALU_CARRY), .IM(im_o[1]), .SEL(sel_o[1]),
    .LOAD(load_o[1]), .CFLAG(cf_o[1]), .ILLEGAL(ill_o[1]), .HALTED(halt_o[1]),
    .RETIRED(ret1));

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Instruction table: returns {legal, sel[1:0], load[3:0]}.
  function automatic logic [6:0] decode(input logic [3:0] op, input logic cf);
    case (op)
      4'h0: return {1'b1, 2'b00, 4'b0001};
      4'h5: return {1'b1, 2'b01, 4'b0010};
      4'h3: return {1'b1, 2'b11, 4'b0001};
      4'h7: return {1'b1, 2'b11, 4'b0010};
      4'h1: return {1'b1, 2'b01, 4'b0001};
      4'h4: return {1'b1, 2'b00, 4'b0010};
      4'h2: return {1'b1, 2'b10, 4'b0001};
      4'h6: return {1'b1, 2'b10, 4'b0010};
      4'hB: return {1'b1, 2'b11, 4'b0100};
      4'h9: return {1'b1, 2'b01, 4'b0100};
      4'hF: return {1'b1, 2'b11, 4'b1000};
      4'hE: return {1'b1, 2'b11, (cf ? 4'b0000 : 4'b1000)};
      default: return {1'b0, 2'b11, 4'b0000};
    endcase
  endfunction

  bit         m_busy  [2];  // an accepted instruction is executing
  bit         m_halt  [2];
  bit         m_legal [2];
  bit         m_cf    [2];
  bit         m_ill   [2];
  logic [1:0] m_sel   [2];
  logic [3:0] m_load  [2];
  logic [3:0] m_im    [2];
  int         m_ret   [2];

  always @(posedge CLK or negedge RST_N) begin
    for (int i = 0; i < 2; i++) begin
      if (!RST_N) begin
        m_busy[i] <= 1'b0; m_halt[i] <= 1'b0; m_legal[i] <= 1'b0;
        m_cf[i] <= 1'b0; m_ill[i] <= 1'b0; m_sel[i] <= 2'b11;
        m_load[i] <= 4'b0; m_im[i] <= 4'b0; m_ret[i] <= 0;
      end else if (m_halt[i]) begin
        m_busy[i] <= 1'b0;
      end else if (m_busy[i]) begin
        m_busy[i] <= 1'b0;
        if (m_legal[i]) begin
          m_cf[i]  <= ALU_CARRY;
          m_ret[i] <= (m_ret[i] + 1) % ((i == 0) ? 65536 : 4);
        end else if (i == 0) begin
          m_halt[i] <= 1'b1;
        end
      end else if (CMD_VALID) begin
        logic [6:0] d;
        d = decode(COMMAND[7:4], m_cf[i]);
        m_busy[i]  <= 1'b1;
        m_legal[i] <= d[6];
        m_sel[i]   <= d[5:4];
        m_load[i]  <= d[3:0];
        m_im[i]    <= COMMAND[3:0];
        if (!d[6]) m_ill[i] <= 1'b1;
      end
    end
  end

  // ---------------- cycle compare ----------------
  always @(negedge CLK) begin
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("dut%0d CMD_READY", i), ready_o[i], !(m_busy[i] || m_halt[i]));
        chk($sformatf("dut%0d HALTED", i), halt_o[i], m_halt[i]);
        chk($sformatf("dut%0d LOAD", i), load_o[i], m_busy[i] ? m_load[i] : 4'b0);
        chk($sformatf("dut%0d SEL", i), sel_o[i], m_sel[i]);
        chk($sformatf("dut%0d IM", i), im_o[i], m_im[i]);
        chk($sformatf("dut%0d CFLAG", i), cf_o[i], m_cf[i]);
        chk($sformatf("dut%0d ILLEGAL", i), ill_o[i], m_ill[i]);
        chk($sformatf("dut%0d RETIRED", i), (i == 0) ? 32'(ret0) : 32'(ret1), m_ret[i]);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Offers cmd in an idle cycle, then returns at the falling edge of its EXEC
  // cycle with ALU_CARRY set to carry.
  task automatic send(input logic [7:0] cmd, input logic carry);
    @(posedge CLK); #1;
    CMD_VALID = 1'b1; COMMAND = cmd;
    @(posedge CLK); #1;
    CMD_VALID = 1'b0; ALU_CARRY = carry;
    @(negedge CLK);
  endtask

  logic [3:0] legal_ops [12] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
                                 4'h6, 4'h7, 4'h9, 4'hB, 4'hE, 4'hF};

  function automatic logic [7:0] rand_cmd();
    logic [3:0] op;
    if ($urandom_range(0, 29) == 0) op = 4'($urandom_range(0, 15));
    else op = legal_ops[$urandom_range(0, 11)];
    return {op, 4'($urandom_range(0, 15))};
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] q [4];
    int idx, pulses, b2b, nacc;
    int acc_k [4];
    bit prev, rdy;

    // Reset values
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    cmp_en = 1'b1;
    chk("rst READY", ready_o[0], 1); chk("rst SEL", sel_o[0], 3);
    chk("rst IM", im_o[0], 0);       chk("rst LOAD", load_o[0], 0);
    chk("rst HALTED", halt_o[0], 0); chk("rst RETIRED", ret0, 0);
    @(posedge CLK); #1 RST_N = 1'b1;

    // MOV A,5
    send(8'h35, 1'b0);
    chk("mov LOAD", load_o[0], 4'b0001); chk("mov SEL", sel_o[0], 2'b11);
    chk("mov IM", im_o[0], 5);
    @(negedge CLK);
    chk("mov LOAD after", load_o[0], 0); chk("mov RETIRED", ret0, 1);
    chk("mov READY after", ready_o[0], 1);

    // Carry, then JNC taken/not-taken
    send(8'h0F, 1'b1);
    chk("add LOAD", load_o[0], 4'b0001); chk("add SEL", sel_o[0], 2'b00);
    @(negedge CLK);
    chk("add CFLAG", cf_o[0], 1);
    send(8'hE3, 1'b0);
    chk("jnc c=1 LOAD", load_o[0], 4'b0000);
    @(negedge CLK);
    send(8'h00, 1'b0);
    @(negedge CLK);
    send(8'hE3, 1'b1);
    chk("jnc c=0 LOAD", load_o[0], 4'b1000); chk("jnc IM", im_o[0], 3);
    @(negedge CLK);
    chk("five RETIRED", ret0, 5);
    chk("wrap RETIRED cnt2", ret1, 1);

    // Continuous CMD_VALID with four queued instructions
    q = '{8'h7A, 8'h42, 8'hB9, 8'h21};
    idx = 0; pulses = 0; b2b = 0; nacc = 0; prev = 1'b0;
    ALU_CARRY = 1'b0;
    @(posedge CLK); #1;
    CMD_VALID = 1'b1; COMMAND = q[0];
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      rdy = ready_o[0];
      if (load_o[0] != 4'b0) begin
        pulses++;
        if (prev) b2b++;
      end
      prev = (load_o[0] != 4'b0);
      @(posedge CLK);
      if (CMD_VALID && rdy) begin
        if (nacc < 4) acc_k[nacc] = k;
        nacc++; idx++;
      end
      #1;
      if (idx < 4) COMMAND = q[idx];
      else CMD_VALID = 1'b0;
    end
    @(negedge CLK);
    chk("b2b accepts", nacc, 4);
    chk("b2b pulses", pulses, 4);
    chk("b2b adjacent pulses", b2b, 0);
    for (int j = 1; j < 4; j++) chk("b2b accept spacing", acc_k[j] - acc_k[j-1], 2);
    chk("b2b RETIRED", ret0, 9);

    // Illegal 1010: dut0 halts, dut1 treats it as NOP
    send(8'hA0, 1'b1);
    chk("ill LOAD", load_o[0], 0); chk("ill ILLEGAL", ill_o[0], 1);
    @(negedge CLK);
    chk("ill HALTED", halt_o[0], 1); chk("ill READY", ready_o[0], 0);
    chk("ill RETIRED", ret0, 9); chk("nop RETIRED cnt2", ret1, 1);
    chk("nop ILLEGAL", ill_o[1], 1);
    send(8'hC0, 1'b0);
    @(negedge CLK);
    send(8'h77, 1'b0);
    chk("movb LOAD", load_o[1], 4'b0010); chk("halted LOAD", load_o[0], 0);
    @(negedge CLK);
    chk("movb RETIRED cnt2", ret1, 2);
    chk("still HALTED", halt_o[0], 1); chk("still not READY", ready_o[0], 0);

    // Reset pulse restores everything
    @(posedge CLK); #2 RST_N = 1'b0;
    #1;
    chk("rp READY", ready_o[0], 1); chk("rp HALTED", halt_o[0], 0);
    chk("rp ILLEGAL", ill_o[0], 0); chk("rp SEL", sel_o[0], 3);
    chk("rp RETIRED", ret0, 0);
    @(posedge CLK); #1 RST_N = 1'b1;

    // Reset asserted in the EXEC cycle
    send(8'h35, 1'b1);
    chk("ax LOAD before", load_o[0], 4'b0001);
    #1 RST_N = 1'b0;
    #1;
    chk("ax LOAD async", load_o[0], 0); chk("ax LOAD async cnt2", load_o[1], 0);
    @(negedge CLK);
    chk("ax RETIRED", ret0, 0); chk("ax CFLAG", cf_o[0], 0);
    @(posedge CLK); #1 RST_N = 1'b1;

    // Randomised traffic with occasional asynchronous resets
    repeat (3000) begin
      @(posedge CLK); #1;
      CMD_VALID = ($urandom_range(0, 99) < 70);
      COMMAND   = rand_cmd();
      ALU_CARRY = 1'($urandom_range(0, 1));
      if (!RST_N) RST_N = 1'b1;
      else if ($urandom_range(0, 199) == 0) begin
        #($urandom_range(1, 3));
        RST_N = 1'b0;
      end
    end

    @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
